// File: rtl/adc_ram_pkg.sv
// Shared types and defaults for the ADC-to-RAM burst writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int DATA_W = 256;

    // Beat counters must represent 0..64 inclusive.
    localparam int BEAT_CNT_W = 7;

    localparam int DEF_BURST_LEN   = 16;
    localparam int DEF_FRAME_WORDS = 4096;
    localparam int DEF_BASE_ADDR   = 0;

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry buffer absorbing the one-cycle FIFO read latency.
// Latency: push visible on out_vld the following cycle.
// Backpressure: holds head stable while out_rdy is low; caller must never push into a full, non-draining buffer.
module fifo_rd_skid2 #(
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              out_rdy,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat,
    output logic [1:0]        occ,
    output logic              pop
);

    logic [DATA_W-1:0] ent0;
    logic [DATA_W-1:0] ent1;
    logic [1:0]        occ_q;

    assign out_vld = (occ_q != 2'd0);
    assign out_dat = ent0;
    assign pop     = out_vld && out_rdy;
    assign occ     = occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) ent0 <= push_dat;
                    else               ent1 <= push_dat;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0 <= push_dat;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && occ_q == 2'd2));
    end

endmodule

// File: rtl/adc_ram_burst_writer.sv
// Drains the capture FIFO in fixed bursts: one address command, then BURST_LEN write beats.
// Latency: cmd_valid one cycle after the count qualifies; first beat 3 cycles after cmd accept.
// Backpressure: cmd held until cmd_ready; wr_ready stalls FIFO reads through a 2-entry buffer.
module adc_ram_burst_writer #(
    parameter int DATA_W      = adc_ram_pkg::DATA_W,
    parameter int ADDR_W      = 29,
    parameter int BURST_LEN   = adc_ram_pkg::DEF_BURST_LEN,
    parameter int COUNT_W     = 7,
    parameter int FRAME_WORDS = adc_ram_pkg::DEF_FRAME_WORDS,
    parameter int BASE_ADDR   = adc_ram_pkg::DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    input  logic               fifo_valid,
    input  logic               fifo_full,
    input  logic [COUNT_W-1:0] fifo_rd_data_count,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [ADDR_W-1:0]  cmd_addr,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [DATA_W-1:0]  wr_data,
    output logic               wr_last,
    output logic               frame_done,
    output logic [15:0]        frame_count,
    output logic               overflow,
    output logic               busy
);
    import adc_ram_pkg::*;

    localparam logic [BEAT_CNT_W-1:0] BURST_BEATS = BEAT_CNT_W'(BURST_LEN);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT   = BEAT_CNT_W'(BURST_LEN - 1);
    localparam logic [BEAT_CNT_W-1:0] BEAT_ONE    = BEAT_CNT_W'(1);
    localparam logic [COUNT_W-1:0]    BURST_WORDS = COUNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0]     ADDR_STEP   = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0]     ADDR_BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]     ADDR_END    = ADDR_W'(BASE_ADDR + FRAME_WORDS);

    state_t                  state;
    logic [ADDR_W-1:0]       addr;
    logic [ADDR_W-1:0]       next_addr;
    logic [BEAT_CNT_W-1:0]   reads_issued;
    logic [BEAT_CNT_W-1:0]   beats_sent;
    logic                    rd_inflight;
    logic [1:0]              occ;
    logic                    pop;
    logic [2:0]              pending;

    fifo_rd_skid2 #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_inflight && fifo_valid),
        .push_dat (fifo_rd_data),
        .out_rdy  (wr_ready),
        .out_vld  (wr_valid),
        .out_dat  (wr_data),
        .occ      (occ),
        .pop      (pop)
    );

    // Words held or on their way must stay within the two buffer slots after this cycle's pop.
    always_comb begin
        pending    = {1'b0, occ} + {2'b00, rd_inflight};
        fifo_rd_en = !rst && (state == ST_DATA) && (reads_issued < BURST_BEATS)
                     && (pending < (3'd2 + {2'b00, pop}));
    end

    assign wr_last   = wr_valid && (beats_sent == LAST_BEAT);
    assign next_addr = addr + ADDR_STEP;
    assign cmd_addr  = addr;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr         <= ADDR_BASE;
            reads_issued <= '0;
            beats_sent   <= '0;
            rd_inflight  <= 1'b0;
            cmd_valid    <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= 16'd0;
            overflow     <= 1'b0;
        end else begin
            rd_inflight <= fifo_rd_en;
            frame_done  <= 1'b0;
            if (fifo_full) overflow <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (enable && fifo_rd_data_count >= BURST_WORDS) begin
                        state     <= ST_CMD;
                        cmd_valid <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (cmd_ready) begin
                        cmd_valid    <= 1'b0;
                        state        <= ST_DATA;
                        reads_issued <= '0;
                        beats_sent   <= '0;
                    end
                end
                ST_DATA: begin
                    if (fifo_rd_en) reads_issued <= reads_issued + BEAT_ONE;
                    if (pop)        beats_sent   <= beats_sent + BEAT_ONE;
                    if (pop && wr_last) begin
                        state <= ST_IDLE;
                        if (next_addr == ADDR_END) begin
                            addr        <= ADDR_BASE;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end else begin
                            addr <= next_addr;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
